// File: rtl/prim_lsu_pkg.sv
// Shared types and constants for the prim load/store unit.
package prim_lsu_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StGap    = 2'd2
    } lsu_state_e;

    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_LO   = 2'b01;
    localparam logic [1:0] BS_WORD = 2'b11;

endpackage

// File: rtl/prim_lsu_rdfmt.sv
// Combinational read-data formatter: word passthrough or zero/sign-extended low byte.
module prim_lsu_rdfmt (
    input  logic [15:0] i_dat,
    input  logic        i_byte,
    input  logic        i_signed,
    output logic [15:0] o_data
);

    always_comb begin
        o_data = i_dat;
        if (i_byte) begin
            o_data = {{8{i_signed & i_dat[7]}}, i_dat[7:0]};
        end
    end

endmodule

// File: rtl/prim_lsu.sv
// Load/store unit: captures one core command, holds the bus request until ack or
// watchdog expiry, then inserts a one-cycle idle gap carrying the done pulse.
module prim_lsu
    import prim_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic        i_byte,
    input  logic        i_signed,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_rdata,
    output logic [15:0] o_addr,
    output logic [15:0] o_dat,
    output logic [1:0]  o_bs,
    output logic        o_we,
    input  logic [15:0] i_dat,
    input  logic        i_ack
);

    localparam logic [15:0] WdLast = 16'(TIMEOUT - 1);

    lsu_state_e  state_q;
    logic [15:0] wdog_q;
    logic        byte_q;
    logic        signed_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] rdata_q;
    logic [15:0] addr_q;
    logic [15:0] dat_q;
    logic [1:0]  bs_q;
    logic        we_q;
    logic [15:0] rd_fmt;

    prim_lsu_rdfmt u_rdfmt (
        .i_dat    (i_dat),
        .i_byte   (byte_q),
        .i_signed (signed_q),
        .o_data   (rd_fmt)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            wdog_q   <= '0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dat_q    <= '0;
            bs_q     <= BS_NONE;
            we_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_req) begin
                        state_q  <= StAccess;
                        busy_q   <= 1'b1;
                        wdog_q   <= '0;
                        byte_q   <= i_byte;
                        signed_q <= i_signed;
                        addr_q   <= i_addr;
                        dat_q    <= i_byte ? {8'h00, i_wdata[7:0]} : i_wdata;
                        bs_q     <= i_byte ? BS_LO : BS_WORD;
                        we_q     <= i_we;
                    end
                end
                StAccess: begin
                    // An ack on the expiry cycle takes priority over the timeout.
                    if (i_ack) begin
                        if (!we_q) begin
                            rdata_q <= rd_fmt;
                        end
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        bs_q    <= BS_NONE;
                        we_q    <= 1'b0;
                        state_q <= StGap;
                    end else if (wdog_q == WdLast) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        bs_q    <= BS_NONE;
                        we_q    <= 1'b0;
                        state_q <= StGap;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                StGap: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    bs_q    <= BS_NONE;
                    we_q    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_rdata = rdata_q;
    assign o_addr  = addr_q;
    assign o_dat   = dat_q;
    assign o_bs    = bs_q;
    assign o_we    = we_q;

endmodule

// File: doc/prim_lsu.md
# prim_lsu

Load/store unit sitting between the prim CPU core and the memory bridge. It accepts single load/store commands from the core and drives the bridge's request side: address, write data, byte select, write enable. It holds the request until the bridge acknowledges, formats read data (zero- or sign-extended byte, or word), and guarantees the idle gap the bridge needs to detect the next transaction start. A watchdog ends the access with an error if no acknowledge ever arrives.

## Interface
- `TIMEOUT`, default 255: number of ACCESS cycles without `i_ack` before the access is aborted with an error. Must be at least 1.
- `i_clk` in 1: single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req` in 1: core command valid, level. Sampled only in IDLE.
- `i_we` in 1: 1 = store, 0 = load.
- `i_byte` in 1: 1 = byte access, 0 = 16-bit word access.
- `i_signed` in 1: byte loads only; 1 = sign-extend, 0 = zero-extend.
- `i_addr` in 16: byte address.
- `i_wdata` in 16: store data. For byte stores, only bits [7:0] are used.
- `o_busy` out 1: high whenever state is not IDLE.
- `o_done` out 1: one-cycle completion pulse.
- `o_err` out 1: valid with `o_done`; 1 = timeout.
- `o_rdata` out 16: formatted load data, valid from `o_done` until the next accept.
- `o_addr` out 16: bus address.
- `o_dat` out 16: bus write data.
- `o_bs` out 2: bus byte select. 00 = no request.
- `o_we` out 1: bus write enable.
- `i_dat` in 16: bus read data.
- `i_ack` in 1: bus acknowledge, one-cycle pulse.

## Operation
**States**
- IDLE
- ACCESS
- GAP

**Transitions**
- **IDLE:** if `i_req` is high, capture `i_we`, `i_byte`, `i_signed`, `i_addr` and `i_wdata`, then go to ACCESS.
- **ACCESS:** all bus outputs are registered and held stable.
  - `o_addr` = captured address.
  - `o_bs` = 2'b01 for byte accesses, 2'b11 for word accesses.
  - `o_we` = captured write flag.
  - `o_dat` = captured data; for byte stores, `{8'h00, wdata[7:0]}`.
  - On `i_ack`: latch the formatted `i_dat` into `o_rdata` (loads only; stores leave `o_rdata` unchanged), then go to GAP with `err=0`.
  - On watchdog expiry: set `o_rdata`=0, then go to GAP with `err=1`.
- **GAP:** one cycle. `o_bs`=0, `o_we`=0, `o_done`=1, `o_err`=err. Then go to IDLE.

**Load data formatting**
- Word load: `i_dat`.
- Byte load, unsigned: `{8'h00, i_dat[7:0]}`.
- Byte load, signed: `{{8{i_dat[7]}}, i_dat[7:0]}`.

**Watchdog**
- 16-bit counter, cleared on entering ACCESS, incremented each ACCESS cycle without `i_ack`.
- Expires when the count equals `TIMEOUT-1` with no `i_ack`.
- If `i_ack` arrives on the expiry cycle, `i_ack` wins and `err=0`.

**Bus rules**
- `o_bs` is 0 in IDLE and GAP, so every transaction is preceded by at least one cycle with `o_bs`=0. The bridge starts on the rising edge of `|bs`.
- `i_ack` is ignored outside ACCESS.
- Unaligned word addresses are passed through unchanged; the bridge splits them.

**Boundary cases**
- `i_req` held high continuously: the next command is accepted in IDLE, so back-to-back accesses are ACCESS, GAP, IDLE, ACCESS.
- `i_reset` mid-access: at the next edge, go to IDLE and drop all bus outputs. No `o_done` is issued. A stale `i_ack` arriving afterwards is ignored.

## Timing
- **Reset values:**
  - `o_busy`=0, `o_done`=0, `o_err`=0
  - `o_rdata`=0, `o_addr`=0, `o_dat`=0
  - `o_bs`=0, `o_we`=0
  - watchdog=0, state=IDLE
- **Minimum latency:** command accepted at edge N → bus valid after N+1 → `i_ack` in the same cycle → `o_done` after edge N+2.
- **Throughput:** at most one access per 3 cycles.
- **Wait states:** each cycle of `i_ack` delay adds exactly one cycle of latency.
- **Timeout:** `o_done` with `o_err=1` occurs `TIMEOUT+1` cycles after accept.
- **Output registering:** all outputs are registered; no combinational path from `i_ack` or `i_dat` to any output.

## Structure
- Shared package `prim_lsu_pkg` contains:
  - state enum: IDLE=2'd0, ACCESS=2'd1, GAP=2'd2
  - byte-select constants `BS_NONE`, `BS_LO`, `BS_WORD`
- One natural sub-module, `prim_lsu_rdfmt`: the combinational read formatter, with inputs `i_dat`, `byte`, `signed` and output 16-bit data.
- FSM and watchdog stay in the top module.

## Test plan
- Word load at 0x0100; bridge acks 2 cycles after `o_bs`=11 and returns 0xBEEF → `o_done` 1 cycle later, `o_rdata`=0xBEEF, `o_err`=0, `o_bs`=00 during GAP.
- Signed byte load at 0x0031, `i_dat`=0x1280 → `o_bs`=01, `o_rdata`=0xFF80. Same access unsigned → `o_rdata`=0x0080.
- Byte store at 0x0040, `i_wdata`=0xABCD → `o_dat`=0x00CD, `o_we`=1, `o_bs`=01 until ack; `o_rdata` unchanged.
- `i_req` held high for 3 word stores with immediate acks → `o_bs` follows the pattern 11,00,00,11,00,00,11 and exactly 3 `o_done` pulses.
- `TIMEOUT`=4, no ack → `o_done`=1 with `o_err`=1 and `o_rdata`=0, 5 cycles after accept. Repeat with `i_ack` on the 4th ACCESS cycle → `o_err`=0.
- Assert `i_reset` in the 2nd ACCESS cycle, then pulse `i_ack` → all outputs at reset values next cycle, no `o_done`, `o_busy`=0.
